// File: rtl/box_avg_decimator_pkg.sv
// Shared constants and type definitions for the ROM->framebuffer copy stages.
// The top-level mode selector codes live here so every copier agrees on them.
package box_avg_decimator_pkg;

  localparam int unsigned DEF_IMG_W  = 160;
  localparam int unsigned DEF_IMG_H  = 120;
  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_RD_LAT = 1;

  typedef enum logic [2:0] {
    MODE_REPLICATE = 3'b000,
    MODE_DECIMATE  = 3'b001,
    MODE_ZOOM_NN   = 3'b010,
    MODE_BOX_AVG   = 3'b011
  } copy_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_ACC,
    ST_WRITE,
    ST_DONE
  } avg_state_e;

endpackage

// File: rtl/box_avg_decimator_if.sv
// Memory-side bundle of a copier: source ROM read port plus framebuffer write port.
interface box_avg_decimator_if #(
  parameter int unsigned ADDR_W = 19
);
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [ADDR_W-1:0] ram_wraddr;
  logic [7:0]        ram_data;
  logic              ram_wren;

  modport master (
    output rom_addr,
    input  rom_data,
    output ram_wraddr,
    output ram_data,
    output ram_wren
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  ram_wraddr,
    input  ram_data,
    input  ram_wren
  );
endinterface

// File: rtl/box_avg_decimator_coord_counter.sv
// Raster counter over the output image: ox wraps at OUT_W-1 and carries into oy.
// The next coordinates are exposed so callers can precompute addresses for them.
module coord_counter #(
  parameter int unsigned OUT_W = 80,
  parameter int unsigned OUT_H = 60,
  parameter int unsigned CW    = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [CW-1:0] ox,
  output logic [CW-1:0] oy,
  output logic [CW-1:0] nxt_ox,
  output logic [CW-1:0] nxt_oy,
  output logic          last
);
  logic x_wrap;

  always_comb begin
    x_wrap = (ox == CW'(OUT_W - 1));
    last   = x_wrap && (oy == CW'(OUT_H - 1));
    nxt_ox = x_wrap ? '0 : ox + CW'(1);
    nxt_oy = x_wrap ? oy + CW'(1) : oy;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      ox <= '0;
      oy <= '0;
    end else if (advance) begin
      ox <= nxt_ox;
      oy <= nxt_oy;
    end
  end
endmodule

// File: rtl/box_avg_decimator.sv
// 2x2 box-average decimating copy from the image ROM into the framebuffer.
// Each output pixel reads four source taps and writes their rounded mean.
module box_avg_decimator
  import box_avg_decimator_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned RD_LAT = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  box_avg_decimator_if.master mem,
  output logic                busy,
  output logic                done
);
  localparam int unsigned OUT_W     = IMG_W / 2;
  localparam int unsigned OUT_H     = IMG_H / 2;
  localparam logic [7:0]  WAIT_LAST = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;

  avg_state_e        state;
  logic [1:0]        tap;
  logic [7:0]        wait_cnt;
  logic [9:0]        acc;
  logic [9:0]        acc_sum;
  logic [9:0]        acc_rnd;
  logic              start_ok;
  logic              advance;
  logic [ADDR_W-1:0] ox, oy, nxt_ox, nxt_oy;
  logic              last_px;

  // Tap bit 1 selects the lower source row, bit 0 the right-hand column.
  function automatic logic [ADDR_W-1:0] src_addr(input logic [ADDR_W-1:0] x,
                                                 input logic [ADDR_W-1:0] y,
                                                 input logic [1:0]        t);
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    row = {y[ADDR_W-2:0], 1'b0} + ADDR_W'(t[1]);
    col = {x[ADDR_W-2:0], 1'b0} + ADDR_W'(t[0]);
    return row * ADDR_W'(IMG_W) + col;
  endfunction

  always_comb begin
    start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
    advance  = (state == ST_WRITE);
    acc_sum  = acc + {2'b00, mem.rom_data};
    acc_rnd  = acc_sum + 10'd2;
  end

  coord_counter #(
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .CW    (ADDR_W)
  ) u_coord (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .advance (advance),
    .ox      (ox),
    .oy      (oy),
    .nxt_ox  (nxt_ox),
    .nxt_oy  (nxt_oy),
    .last    (last_px)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      tap            <= '0;
      wait_cnt       <= '0;
      acc            <= '0;
      mem.rom_addr   <= '0;
      mem.ram_wraddr <= '0;
      mem.ram_data   <= '0;
      mem.ram_wren   <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state        <= ST_ADDR;
            tap          <= '0;
            acc          <= '0;
            mem.rom_addr <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
          end
        end
        ST_ADDR: begin
          if (RD_LAT > 1) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end else begin
            state <= ST_ACC;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_LAST) state <= ST_ACC;
          else                       wait_cnt <= wait_cnt + 8'd1;
        end
        ST_ACC: begin
          acc <= acc_sum;
          // Final tap folds the live ROM word straight into the rounded result.
          if (tap == 2'd3) begin
            state          <= ST_WRITE;
            mem.ram_wren   <= 1'b1;
            mem.ram_wraddr <= ADDR_W'(OUT_W) * oy + ox;
            mem.ram_data   <= acc_rnd[9:2];
          end else begin
            state        <= ST_ADDR;
            tap          <= tap + 2'd1;
            mem.rom_addr <= src_addr(ox, oy, tap + 2'd1);
          end
        end
        ST_WRITE: begin
          mem.ram_wren <= 1'b0;
          if (last_px) begin
            state        <= ST_DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            mem.rom_addr <= '0;
          end else begin
            state        <= ST_ADDR;
            tap          <= '0;
            acc          <= '0;
            mem.rom_addr <= src_addr(nxt_ox, nxt_oy, 2'd0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_box_avg_decimator.sv
// Scoreboard bench for box_avg_decimator: 160x120 RD_LAT=1 instance plus a
// small odd-sized RD_LAT=2 instance.
module tb_box_avg_decimator;
  localparam int unsigned W     = 160;
  localparam int unsigned H     = 120;
  localparam int unsigned OW    = 80;
  localparam int unsigned OH    = 60;
  localparam int unsigned NPIX  = OW * OH;
  localparam int unsigned W2    = 17;
  localparam int unsigned H2    = 11;
  localparam int unsigned OW2   = 8;
  localparam int unsigned OH2   = 5;
  localparam int unsigned NPIX2 = OW2 * OH2;

  typedef struct packed {
    logic [18:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic start2;
  logic busy, done, busy2, done2;

  always #5 clk = ~clk;

  box_avg_decimator_if #(.ADDR_W(19)) m_if ();
  box_avg_decimator_if #(.ADDR_W(19)) s_if ();

  box_avg_decimator dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mem   (m_if),
    .busy  (busy),
    .done  (done)
  );

  box_avg_decimator #(
    .IMG_W  (W2),
    .IMG_H  (H2),
    .ADDR_W (19),
    .RD_LAT (2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .start (start2),
    .mem   (s_if),
    .busy  (busy2),
    .done  (done2)
  );

  logic [7:0] rom  [0:W*H-1];
  logic [7:0] rom2 [0:W2*H2-1];
  logic [7:0] rom2_p;

  always @(posedge clk) m_if.rom_data <= rom[15'(m_if.rom_addr)];
  always @(posedge clk) begin
    rom2_p        <= rom2[8'(s_if.rom_addr)];
    s_if.rom_data <= rom2_p;
  end

  // Write capture (one writer per variable; tasks only read these)
  logic [18:0] obs_addr [0:16383];
  logic [7:0]  obs_data [0:16383];
  int unsigned obs_n = 0;
  logic [18:0] obs2_addr [0:255];
  logic [7:0]  obs2_data [0:255];
  int unsigned obs2_n = 0;
  int unsigned bad_rd2 = 0;

  always @(negedge clk) begin
    if (m_if.ram_wren === 1'b1) begin
      obs_addr[obs_n[13:0]] <= m_if.ram_wraddr;
      obs_data[obs_n[13:0]] <= m_if.ram_data;
      obs_n <= obs_n + 1;
    end
  end

  always @(negedge clk) begin
    if (s_if.ram_wren === 1'b1) begin
      obs2_addr[obs2_n[7:0]] <= s_if.ram_wraddr;
      obs2_data[obs2_n[7:0]] <= s_if.ram_data;
      obs2_n <= obs2_n + 1;
    end
    if (busy2 === 1'b1 && ((s_if.rom_addr % W2) == W2 - 1 || s_if.rom_addr >= W2 * (H2 - 1)))
      bad_rd2 <= bad_rd2 + 1;
  end

  wr_t exp_q[$];
  wr_t exp2_q[$];
  int unsigned rd_idx = 0;
  int unsigned rd2_idx = 0;
  int vectors = 0;
  int miscompares = 0;

  function automatic logic [7:0] avg_main(int unsigned ox, int unsigned oy);
    int unsigned s;
    int unsigned b;
    b = 2 * oy * W + 2 * ox;
    s = rom[b] + rom[b+1] + rom[b+W] + rom[b+W+1];
    return 8'((s + 2) / 4);
  endfunction

  function automatic logic [7:0] avg_small(int unsigned ox, int unsigned oy);
    int unsigned s;
    int unsigned b;
    b = 2 * oy * W2 + 2 * ox;
    s = rom2[b] + rom2[b+1] + rom2[b+W2] + rom2[b+W2+1];
    return 8'((s + 2) / 4);
  endfunction

  task automatic push_frame();
    exp_q.delete();
    for (int unsigned oy = 0; oy < OH; oy++)
      for (int unsigned ox = 0; ox < OW; ox++)
        exp_q.push_back({19'(oy * OW + ox), avg_main(ox, oy)});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({m_if.rom_addr, m_if.ram_wraddr, m_if.ram_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_bus got rom_addr=%0d wraddr=%0d data=%0d want 0 0 0",
               m_if.rom_addr, m_if.ram_wraddr, m_if.ram_data);
    end
    vectors++;
    if ({m_if.ram_wren, busy, done, s_if.ram_wren, busy2, done2} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got wren/busy/done=%b%b%b dut2=%b%b%b want 000 000",
               m_if.ram_wren, busy, done, s_if.ram_wren, busy2, done2);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_const_frame();
    int done_cyc, wr0, wr1, w4798;
    int unsigned base, k;
    logic [18:0] exp_ra;
    wr_t e;
    for (int i = 0; i < W * H; i++) rom[i] = 8'd100;
    push_frame();
    @(negedge clk);
    base = obs_n; rd_idx = obs_n;
    done_cyc = -1; wr0 = -1; wr1 = -1; w4798 = -1;
    start = 1'b1;
    for (int cyc = 0; cyc < 45000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      if (m_if.ram_wren === 1'b1 && m_if.ram_wraddr == 0 && wr0 < 0) wr0 = cyc;
      if (m_if.ram_wren === 1'b1 && m_if.ram_wraddr == 1 && wr1 < 0) wr1 = cyc;
      if (m_if.ram_wren === 1'b1 && m_if.ram_wraddr == NPIX - 2) w4798 = cyc;
      if (w4798 >= 0 && cyc > w4798 && cyc <= w4798 + 7 && ((cyc - w4798) % 2) == 1) begin
        k = (cyc - w4798 - 1) / 2;
        exp_ra = 19'((2 * (OH - 1) + k / 2) * W + 2 * (OW - 1) + k % 2);
        vectors++;
        if (m_if.rom_addr !== exp_ra) begin
          miscompares++;
          $display("FAIL last_px_rom_addr tap%0d got %0d want %0d", k, m_if.rom_addr, exp_ra);
        end
      end
      while (rd_idx < obs_n) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL const_extra_write got addr=%0d want none", obs_addr[rd_idx[13:0]]);
        end else begin
          e = exp_q.pop_front();
          if (obs_addr[rd_idx[13:0]] !== e.addr || obs_data[rd_idx[13:0]] !== e.data) begin
            miscompares++;
            $display("FAIL const_write got addr=%0d data=%0d want addr=%0d data=%0d",
                     obs_addr[rd_idx[13:0]], obs_data[rd_idx[13:0]], e.addr, e.data);
          end
        end
        rd_idx++;
      end
      if (done === 1'b1) begin done_cyc = cyc; break; end
    end
    vectors++;
    if (done_cyc != 43200) begin
      miscompares++;
      $display("FAIL const_done_cycle got %0d want 43200", done_cyc);
    end
    vectors++;
    if (wr0 != 8 || wr1 - wr0 != 9) begin
      miscompares++;
      $display("FAIL const_pixel_timing got first=%0d gap=%0d want first=8 gap=9", wr0, wr1 - wr0);
    end
    vectors++;
    if (w4798 < 0 || done_cyc != w4798 + 10) begin
      miscompares++;
      $display("FAIL last_px_done got done=%0d w4798=%0d want done=w4798+10", done_cyc, w4798);
    end
    vectors++;
    if (obs_n - base != NPIX || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL const_write_count got %0d left=%0d want %0d left=0",
               obs_n - base, exp_q.size(), NPIX);
    end
  endtask

  task automatic test_blocks_reset();
    int unsigned base;
    bit hit;
    logic [7:0] want_d [4];
    wr_t e;
    for (int i = 0; i < W * H; i++) rom[i] = 8'($urandom_range(0, 255));
    rom[0] = 8'd10;  rom[1] = 8'd11;  rom[W]   = 8'd12;  rom[W+1] = 8'd13;
    rom[2] = 8'd255; rom[3] = 8'd255; rom[W+2] = 8'd255; rom[W+3] = 8'd255;
    rom[4] = 8'd1;   rom[5] = 8'd0;   rom[W+4] = 8'd0;   rom[W+5] = 8'd0;
    rom[6] = 8'd1;   rom[7] = 8'd1;   rom[W+6] = 8'd0;   rom[W+7] = 8'd0;
    want_d[0] = 8'd12; want_d[1] = 8'd255; want_d[2] = 8'd0; want_d[3] = 8'd1;
    push_frame();
    @(negedge clk);
    base = obs_n; rd_idx = obs_n; hit = 1'b0;
    start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start = 1'b0;
      while (rd_idx < obs_n) begin
        vectors++;
        e = exp_q.pop_front();
        if (obs_addr[rd_idx[13:0]] !== e.addr || obs_data[rd_idx[13:0]] !== e.data) begin
          miscompares++;
          $display("FAIL block_write got addr=%0d data=%0d want addr=%0d data=%0d",
                   obs_addr[rd_idx[13:0]], obs_data[rd_idx[13:0]], e.addr, e.data);
        end
        rd_idx++;
      end
      if (m_if.ram_wren === 1'b1 && m_if.ram_wraddr == 100) begin
        reset = 1'b1;
        hit = 1'b1;
        break;
      end
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL reach_pixel_100 got timeout want write to addr 100");
    end
    @(negedge clk);
    vectors++;
    if ({m_if.ram_wren, busy, done} !== 3'b000 || m_if.rom_addr !== 19'd0) begin
      miscompares++;
      $display("FAIL abort_state got wren/busy/done=%b%b%b rom_addr=%0d want 000 0",
               m_if.ram_wren, busy, done, m_if.rom_addr);
    end
    reset = 1'b0;
    repeat (300) @(negedge clk);
    vectors++;
    if (obs_n - base != 101) begin
      miscompares++;
      $display("FAIL abort_no_more_writes got %0d writes want 101", obs_n - base);
    end
    for (int unsigned i = 0; i < 4; i++) begin
      vectors++;
      if (obs_addr[14'(base + i)] !== 19'(i) || obs_data[14'(base + i)] !== want_d[i]) begin
        miscompares++;
        $display("FAIL block%0d got addr=%0d data=%0d want addr=%0d data=%0d",
                 i, obs_addr[14'(base + i)], obs_data[14'(base + i)], i, want_d[i]);
      end
    end
    rd_idx = obs_n;
    exp_q.delete();
  endtask

  task automatic test_restart_busy_start();
    int done_cyc;
    int unsigned base;
    wr_t e;
    push_frame();
    @(negedge clk);
    base = obs_n; rd_idx = obs_n; done_cyc = -1;
    start = 1'b1;
    for (int cyc = 0; cyc < 45000; cyc++) begin
      @(negedge clk);
      start = (cyc == 40 || cyc == 5000 || cyc == 30000 || cyc == 43190) ? 1'b1 : 1'b0;
      while (rd_idx < obs_n) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL restart_extra_write got addr=%0d want none", obs_addr[rd_idx[13:0]]);
        end else begin
          e = exp_q.pop_front();
          if (obs_addr[rd_idx[13:0]] !== e.addr || obs_data[rd_idx[13:0]] !== e.data) begin
            miscompares++;
            $display("FAIL restart_write got addr=%0d data=%0d want addr=%0d data=%0d",
                     obs_addr[rd_idx[13:0]], obs_data[rd_idx[13:0]], e.addr, e.data);
          end
        end
        rd_idx++;
      end
      if (done === 1'b1) begin done_cyc = cyc; break; end
    end
    start = 1'b0;
    vectors++;
    if (done_cyc != 43200) begin
      miscompares++;
      $display("FAIL restart_done_cycle got %0d want 43200", done_cyc);
    end
    vectors++;
    if (obs_n - base != NPIX || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL restart_write_count got %0d left=%0d want %0d left=0",
               obs_n - base, exp_q.size(), NPIX);
    end
  endtask

  task automatic test_rdlat2_odd();
    int done_cyc, wr0, wr1;
    int unsigned base;
    wr_t e;
    for (int i = 0; i < W2 * H2; i++) rom2[i] = 8'($urandom_range(0, 255));
    for (int unsigned r = 0; r < H2; r++) rom2[r * W2 + W2 - 1] = 8'd255;
    for (int unsigned c = 0; c < W2; c++) rom2[(H2 - 1) * W2 + c] = 8'd255;
    exp2_q.delete();
    for (int unsigned oy = 0; oy < OH2; oy++)
      for (int unsigned ox = 0; ox < OW2; ox++)
        exp2_q.push_back({19'(oy * OW2 + ox), avg_small(ox, oy)});
    @(negedge clk);
    base = obs2_n; rd2_idx = obs2_n; done_cyc = -1; wr0 = -1; wr1 = -1;
    start2 = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (cyc == 0) start2 = 1'b0;
      if (s_if.ram_wren === 1'b1 && s_if.ram_wraddr == 0 && wr0 < 0) wr0 = cyc;
      if (s_if.ram_wren === 1'b1 && s_if.ram_wraddr == 1 && wr1 < 0) wr1 = cyc;
      while (rd2_idx < obs2_n) begin
        vectors++;
        if (exp2_q.size() == 0) begin
          miscompares++;
          $display("FAIL lat2_extra_write got addr=%0d want none", obs2_addr[rd2_idx[7:0]]);
        end else begin
          e = exp2_q.pop_front();
          if (obs2_addr[rd2_idx[7:0]] !== e.addr || obs2_data[rd2_idx[7:0]] !== e.data) begin
            miscompares++;
            $display("FAIL lat2_write got addr=%0d data=%0d want addr=%0d data=%0d",
                     obs2_addr[rd2_idx[7:0]], obs2_data[rd2_idx[7:0]], e.addr, e.data);
          end
        end
        rd2_idx++;
      end
      if (done2 === 1'b1) begin done_cyc = cyc; break; end
    end
    vectors++;
    if (done_cyc != NPIX2 * 13) begin
      miscompares++;
      $display("FAIL lat2_done_cycle got %0d want %0d", done_cyc, NPIX2 * 13);
    end
    vectors++;
    if (wr0 != 12 || wr1 - wr0 != 13) begin
      miscompares++;
      $display("FAIL lat2_pixel_timing got first=%0d gap=%0d want first=12 gap=13", wr0, wr1 - wr0);
    end
    vectors++;
    if (obs2_n - base != NPIX2 || exp2_q.size() != 0) begin
      miscompares++;
      $display("FAIL lat2_write_count got %0d left=%0d want %0d left=0",
               obs2_n - base, exp2_q.size(), NPIX2);
    end
    vectors++;
    if (bad_rd2 != 0) begin
      miscompares++;
      $display("FAIL odd_trailing_reads got %0d want 0", bad_rd2);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    start2 = 1'b0;
    test_reset();
    test_const_frame();
    test_blocks_reset();
    test_restart_busy_start();
    test_rdlat2_odd();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
